store_trace_drain: RTL and testbench

- Captures CPU data-memory stores (memwrite, dataadr, writedata) from the pipelined MIPS core and queues them in a FIFO.
- A host-side consumer drains the queue through a valid/ready handshake.
- Also flags the end-of-test store pattern: a store of value 0 to a fixed address.
- Sits beside the data memory at top level. It is the reader end of the CPU store stream and replaces ad-hoc checking of that stream.

---
 rtl/store_trace_drain.sv | 153 +++++++++++++++
 tb/tb_store_trace_drain.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_trace_drain.sv
// store_trace_drain: captures CPU data-memory stores inside an address window
// into a FIFO, drains them to a host consumer over valid/ready, and raises
// sticky flags for dropped stores, misaligned stores and the end-of-test store.
module store_trace_drain #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] WIN_LO    = 32'h0000_0000,
    parameter logic [31:0] WIN_HI    = 32'h0000_00FF,
    parameter logic [31:0] DONE_ADDR = 32'd88
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               memwrite,
    input  logic [31:0]              dataadr,
    input  logic [31:0]              writedata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_data,
    output logic [1:0]               out_size,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     misalign,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] SIZE_NONE = 2'b00;
    localparam logic [1:0] SIZE_WORD = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_BYTE = 2'b11;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            misalign_q, misalign_d;
    logic            done_q, done_d;

    logic            store_present;
    logic            store_aligned;
    logic            in_window;
    logic            qualifying;
    logic            fifo_full;
    logic            do_push;
    logic            do_pop;
    logic            done_hit;
    entry_t          new_entry;

    // Classify the incoming store: alignment, window membership, payload masking.
    always_comb begin
        store_present = (memwrite != SIZE_NONE);
        store_aligned = 1'b1;
        new_entry     = '0;
        new_entry.addr = dataadr;
        new_entry.size = memwrite;
        case (memwrite)
            SIZE_WORD: begin
                store_aligned  = (dataadr[1:0] == 2'b00);
                new_entry.data = writedata;
            end
            SIZE_HALF: begin
                store_aligned  = (dataadr[0] == 1'b0);
                new_entry.data = {16'h0000, writedata[15:0]};
            end
            SIZE_BYTE: begin
                store_aligned  = 1'b1;
                new_entry.data = {24'h00_0000, writedata[7:0]};
            end
            default: begin
                store_aligned  = 1'b1;
                new_entry.data = '0;
            end
        endcase
        // Offset form of WIN_LO <= dataadr <= WIN_HI, valid for unsigned wrap.
        in_window  = ((dataadr - WIN_LO) <= (WIN_HI - WIN_LO));
        qualifying = store_present && store_aligned && in_window;
        done_hit   = (memwrite == SIZE_WORD) && (dataadr == DONE_ADDR) &&
                     (writedata == 32'h0000_0000);
    end

    // Decide push/pop and compute next pointer, occupancy and sticky flag values.
    always_comb begin
        fifo_full  = (count_q == FULL_COUNT);
        do_pop     = (count_q != '0) && out_ready;
        do_push    = qualifying && (!fifo_full || do_pop);
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        if (do_push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q || (qualifying && fifo_full && !do_pop);
        misalign_d = misalign_q || (store_present && !store_aligned);
        done_d     = done_q || done_hit;
    end

    // Control state: pointers, occupancy and sticky flags, cleared by async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            misalign_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            misalign_q <= misalign_d;
            done_q     <= done_d;
        end
    end

    // Entry storage needs no reset: contents only matter while count covers them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= new_entry;
        end
    end

    // Head entry and status are presented straight from the registered state.
    always_comb begin
        out_valid = (count_q != '0);
        out_addr  = mem_q[rptr_q].addr;
        out_data  = mem_q[rptr_q].data;
        out_size  = mem_q[rptr_q].size;
        count     = count_q;
        overflow  = overflow_q;
        misalign  = misalign_q;
        done      = done_q;
    end

endmodule

// File: tb/tb_store_trace_drain.sv
// Testbench for store_trace_drain: directed stores with hand-computed expected
// entries pushed into a scoreboard; a monitor pops and compares on each transfer.
module tb_store_trace_drain;

    logic        clk;
    logic        reset;
    logic [1:0]  memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [1:0]  out_size;
    logic [3:0]  count;
    logic        overflow;
    logic        misalign;
    logic        done;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    store_trace_drain #(
        .DEPTH(8),
        .WIN_LO(32'h0000_0000),
        .WIN_HI(32'h0000_00FF),
        .DONE_ADDR(32'd88)
    ) dut (
        .clk(clk),
        .reset(reset),
        .memwrite(memwrite),
        .dataadr(dataadr),
        .writedata(writedata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr(out_addr),
        .out_data(out_data),
        .out_size(out_size),
        .count(count),
        .overflow(overflow),
        .misalign(misalign),
        .done(done)
    );

    // 140 ns clock period
    initial begin
        clk = 1'b0;
        forever #70 clk = ~clk;
    end

    // Compare one value and record the outcome
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Advance one clock and settle past the edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one store for one cycle; record its expected entry if it should be queued
    task automatic applyStimulus(input logic [1:0] mw, input logic [31:0] adr,
                                 input logic [31:0] wd, input bit exp_q,
                                 input logic [31:0] exp_data);
        exp_t e;
        memwrite  = mw;
        dataadr   = adr;
        writedata = wd;
        @(posedge clk);
        #1;
        if (exp_q) begin
            e.addr = adr;
            e.data = exp_data;
            e.size = mw;
            sb.push_back(e);
        end
        memwrite = 2'b00;
    endtask

    // Monitor: mid-cycle, a valid&ready head will transfer at the next edge
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_entry_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("head_addr", out_addr, e.addr);
                checkOutput("head_data", out_data, e.data);
                checkOutput("head_size", {30'd0, out_size}, {30'd0, e.size});
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #(140 * 3000);
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset     = 1'b1;
        memwrite  = 2'b00;
        dataadr   = '0;
        writedata = '0;
        out_ready = 1'b0;

        // Reset state
        #11;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_count", {28'd0, count}, 32'd0);
        checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("rst_misalign", {31'd0, misalign}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        #11;
        reset = 1'b0;
        cycle();

        // Word store, no same-cycle bypass, then held stable with ready low
        memwrite  = 2'b01;
        dataadr   = 32'h10;
        writedata = 32'hDEADBEEF;
        #5;
        checkOutput("no_bypass_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        sb.push_back('{addr: 32'h10, data: 32'hDEADBEEF, size: 2'b01});
        memwrite = 2'b00;
        checkOutput("word_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("word_count", {28'd0, count}, 32'd1);
        checkOutput("word_addr", out_addr, 32'h10);
        checkOutput("word_data", out_data, 32'hDEADBEEF);
        checkOutput("word_size", {30'd0, out_size}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("hold_addr", out_addr, 32'h10);
            checkOutput("hold_data", out_data, 32'hDEADBEEF);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        checkOutput("word_pop_count", {28'd0, count}, 32'd0);
        checkOutput("word_pop_valid", {31'd0, out_valid}, 32'd0);

        // Byte / halfword masking and a misaligned halfword
        applyStimulus(2'b11, 32'h13, 32'h123456AB, 1, 32'h000000AB);
        applyStimulus(2'b10, 32'h22, 32'hFFFF8001, 1, 32'h00008001);
        applyStimulus(2'b10, 32'h21, 32'h00001234, 0, 32'h0);
        checkOutput("misalign_set", {31'd0, misalign}, 32'd1);
        checkOutput("misalign_count", {28'd0, count}, 32'd2);
        out_ready = 1'b1;
        cycle();
        cycle();
        out_ready = 1'b0;
        checkOutput("mask_drained", {28'd0, count}, 32'd0);

        // Fill, overflow, then push+pop while full
        for (int i = 0; i < 8; i++) begin
            applyStimulus(2'b01, 32'h40 + 32'(4 * i), 32'h1000 + 32'(i), 1,
                          32'h1000 + 32'(i));
        end
        checkOutput("full_count", {28'd0, count}, 32'd8);
        checkOutput("full_no_overflow", {31'd0, overflow}, 32'd0);
        applyStimulus(2'b01, 32'h80, 32'h9999, 0, 32'h0);
        checkOutput("overflow_set", {31'd0, overflow}, 32'd1);
        checkOutput("overflow_count", {28'd0, count}, 32'd8);
        out_ready = 1'b1;
        applyStimulus(2'b01, 32'h84, 32'hCAFE, 1, 32'hCAFE);
        checkOutput("full_pushpop_count", {28'd0, count}, 32'd8);
        repeat (8) cycle();
        out_ready = 1'b0;
        checkOutput("full_drained", {28'd0, count}, 32'd0);

        // Mid-stream reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b01, 32'hA0 + 32'(4 * i), 32'h5000 + 32'(i), 1,
                          32'h5000 + 32'(i));
        end
        checkOutput("pre_reset_count", {28'd0, count}, 32'd3);
        @(negedge clk);
        #10;
        reset = 1'b1;
        sb.delete();
        #1;
        checkOutput("midrst_count", {28'd0, count}, 32'd0);
        checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("midrst_misalign", {31'd0, misalign}, 32'd0);
        #10;
        reset = 1'b0;
        cycle();

        // Out-of-window store and the end-of-test pattern
        applyStimulus(2'b01, 32'h100, 32'h77, 0, 32'h0);
        checkOutput("outwin_count", {28'd0, count}, 32'd0);
        checkOutput("outwin_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("outwin_misalign", {31'd0, misalign}, 32'd0);
        applyStimulus(2'b01, 32'd88, 32'd5, 1, 32'd5);
        checkOutput("done_nonzero", {31'd0, done}, 32'd0);
        applyStimulus(2'b10, 32'd88, 32'd0, 1, 32'd0);
        checkOutput("done_half", {31'd0, done}, 32'd0);
        applyStimulus(2'b11, 32'd88, 32'd0, 1, 32'd0);
        checkOutput("done_byte", {31'd0, done}, 32'd0);
        applyStimulus(2'b01, 32'd88, 32'd0, 1, 32'd0);
        checkOutput("done_set", {31'd0, done}, 32'd1);
        checkOutput("done_queued_count", {28'd0, count}, 32'd4);
        out_ready = 1'b1;
        repeat (4) cycle();
        out_ready = 1'b0;
        checkOutput("done_drained", {28'd0, count}, 32'd0);

        // 20 stores with ready toggling every cycle, through pointer wrap
        n = 0;
        for (int k = 0; k < 30; k++) begin
            out_ready = k[0];
            if ((k % 3) != 2) begin
                applyStimulus(2'b01, 32'(4 * n), 32'hA500_0000 + 32'(n), 1,
                              32'hA500_0000 + 32'(n));
                n++;
            end else begin
                cycle();
            end
        end
        out_ready = 1'b1;
        repeat (10) cycle();
        out_ready = 1'b0;
        checkOutput("stream_drained", {28'd0, count}, 32'd0);
        checkOutput("stream_no_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("done_sticky", {31'd0, done}, 32'd1);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
